// File: rtl/operand_fwd_unit.sv
// EX-stage operand/bypass unit: ID_EX operand registers, destination tags for NSTG post-EX
// stages, self-computed bypass selects, stall-time operand refresh and load-use detection.
module operand_fwd_unit #(
  parameter int DW   = 16,
  parameter int AW   = 4,
  parameter int NSRC = 2,
  parameter int NSTG = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_ID_EX,
  input  logic               stall_EX_DM,
  input  logic               flush_ID_EX,
  input  logic [NSRC*AW-1:0] rs_addr_ID,
  input  logic [NSRC-1:0]    rs_vld_ID,
  input  logic [NSRC*DW-1:0] rf_rd_data,
  input  logic [AW-1:0]      dst_addr_ID,
  input  logic               dst_we_ID,
  input  logic               dst_ld_ID,
  input  logic [NSTG*DW-1:0] stg_data,
  output logic [NSRC*DW-1:0] opnd,
  output logic [DW-1:0]      st_data_EX_DM,
  output logic [NSRC-1:0]    byp_hit,
  output logic               load_use_haz
);

  // Tag k: k=0 is the instruction in EX, k=1..NSTG the post-EX stages.
  // The load flag only matters in T0 (hazard) and T1 (illegal bypass), so it is kept there only.
  logic [AW-1:0]   r_tag_addr [NSTG+1];
  logic [NSTG:0]   r_tag_we;
  logic [1:0]      r_tag_ld;

  logic [DW-1:0]   r_opnd [NSRC];
  logic [AW-1:0]   r_src  [NSRC];
  logic [NSRC-1:0] r_pend;
  logic [DW-1:0]   r_st_data;

  logic [NSRC-1:0] w_hit;
  logic [DW-1:0]   w_fwd [NSRC];
  logic [NSRC-1:0] w_t1_ld_hit;
  logic            w_haz;

  always_comb begin
    w_hit       = '0;
    w_t1_ld_hit = '0;
    for (int i = 0; i < NSRC; i++) begin
      w_fwd[i] = r_opnd[i];
      // Scan oldest to youngest so the smallest matching stage wins.
      for (int k = NSTG; k >= 1; k--) begin
        if (r_pend[i] && (r_src[i] != '0) && r_tag_we[k] && (r_tag_addr[k] == r_src[i])) begin
          w_hit[i] = 1'b1;
          w_fwd[i] = stg_data[(k-1)*DW +: DW];
        end
      end
      w_t1_ld_hit[i] = r_pend[i] && (r_src[i] != '0) && r_tag_we[1] && r_tag_ld[1] &&
                       (r_tag_addr[1] == r_src[i]);
    end
  end

  always_comb begin
    w_haz = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (r_tag_we[0] && r_tag_ld[0] && (r_tag_addr[0] != '0) && rs_vld_ID[i] &&
          (rs_addr_ID[i*AW +: AW] == r_tag_addr[0]))
        w_haz = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k <= NSTG; k++) begin
        r_tag_addr[k] <= '0;
      end
      r_tag_we <= '0;
      r_tag_ld <= '0;
    end else begin
      if (!stall_EX_DM) begin
        for (int k = NSTG; k >= 2; k--) begin
          r_tag_addr[k] <= r_tag_addr[k-1];
          r_tag_we[k]   <= r_tag_we[k-1];
        end
        r_tag_addr[1] <= stall_ID_EX ? '0 : r_tag_addr[0];
        r_tag_we[1]   <= stall_ID_EX ? 1'b0 : r_tag_we[0];
        r_tag_ld[1]   <= stall_ID_EX ? 1'b0 : r_tag_ld[0];
      end
      if (!stall_ID_EX) begin
        r_tag_addr[0] <= flush_ID_EX ? '0 : dst_addr_ID;
        r_tag_we[0]   <= flush_ID_EX ? 1'b0 : dst_we_ID;
        r_tag_ld[0]   <= flush_ID_EX ? 1'b0 : dst_ld_ID;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NSRC; i++) begin
        r_opnd[i] <= '0;
        r_src[i]  <= '0;
      end
      r_pend    <= '0;
      r_st_data <= '0;
    end else begin
      if (!stall_EX_DM) begin
        r_st_data <= w_fwd[0];
      end
      if (!stall_ID_EX) begin
        for (int i = 0; i < NSRC; i++) begin
          r_opnd[i] <= rf_rd_data[i*DW +: DW];
          r_src[i]  <= rs_addr_ID[i*AW +: AW];
          r_pend[i] <= rs_vld_ID[i] && (rs_addr_ID[i*AW +: AW] != '0) && !flush_ID_EX;
        end
      end else begin
        // Capture forwarded data while held so a retiring producer is not lost.
        for (int i = 0; i < NSRC; i++) begin
          if (w_hit[i]) begin
            r_opnd[i] <= w_fwd[i];
            r_pend[i] <= 1'b0;
          end
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_opnd
      assign opnd[gi*DW +: DW] = w_fwd[gi];
    end
  endgenerate

  assign byp_hit       = w_hit;
  assign st_data_EX_DM = r_st_data;
  assign load_use_haz  = w_haz;

  a_no_ld_hit_t1: assert property (@(posedge clk) rst_n |-> (w_t1_ld_hit == '0));
  a_stall_order:  assert property (@(posedge clk) (rst_n && stall_EX_DM) |-> stall_ID_EX);

endmodule

// File: tb/tb_operand_fwd_unit.sv
// Bench for operand_fwd_unit: directed scenarios with fixed expectations, then randomized
// traffic checked against an instruction-level reference model.
module tb_operand_fwd_unit;

  logic        clk;
  logic        rst_n;
  logic        stall_ID_EX, stall_EX_DM, flush_ID_EX;
  logic [7:0]  rs_addr_ID;
  logic [1:0]  rs_vld_ID;
  logic [31:0] rf_rd_data;
  logic [3:0]  dst_addr_ID;
  logic        dst_we_ID, dst_ld_ID;
  logic [31:0] stg_data;
  logic [31:0] opnd;
  logic [15:0] st_data_EX_DM;
  logic [1:0]  byp_hit;
  logic        load_use_haz;

  int n_cmp = 0;
  int n_bad = 0;

  operand_fwd_unit #(.DW(16), .AW(4), .NSRC(2), .NSTG(2)) dut (
    .clk(clk), .rst_n(rst_n), .stall_ID_EX(stall_ID_EX), .stall_EX_DM(stall_EX_DM),
    .flush_ID_EX(flush_ID_EX), .rs_addr_ID(rs_addr_ID), .rs_vld_ID(rs_vld_ID),
    .rf_rd_data(rf_rd_data), .dst_addr_ID(dst_addr_ID), .dst_we_ID(dst_we_ID),
    .dst_ld_ID(dst_ld_ID), .stg_data(stg_data), .opnd(opnd), .st_data_EX_DM(st_data_EX_DM),
    .byp_hit(byp_hit), .load_use_haz(load_use_haz)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: which instruction occupies EX and each later stage, plus per-source state.
  typedef struct packed { logic [3:0] dst; logic we; logic ld; } ins_t;
  localparam ins_t BUB = 6'b0;
  ins_t        m_ex;
  ins_t        m_stg [1:2];
  logic [15:0] m_val [2];
  logic [3:0]  m_src [2];
  bit          m_wait [2];
  logic [15:0] m_st;

  function automatic void model_clear();
    m_ex = BUB; m_stg[1] = BUB; m_stg[2] = BUB; m_st = 16'h0;
    for (int i = 0; i < 2; i++) begin
      m_val[i] = 16'h0; m_src[i] = 4'h0; m_wait[i] = 1'b0;
    end
  endfunction

  function automatic void m_eval(input int i, output logic [15:0] v, output bit h);
    h = 1'b0;
    v = m_val[i];
    if (m_wait[i] && m_src[i] != 4'h0)
      for (int k = 1; k <= 2; k++)
        if (!h && m_stg[k].we && m_stg[k].dst == m_src[i]) begin
          h = 1'b1;
          v = stg_data[(k-1)*16 +: 16];
        end
  endfunction

  function automatic bit m_haz();
    bit h;
    h = 1'b0;
    for (int i = 0; i < 2; i++)
      if (m_ex.we && m_ex.ld && m_ex.dst != 4'h0 && rs_vld_ID[i] && rs_addr_ID[i*4 +: 4] == m_ex.dst)
        h = 1'b1;
    return h;
  endfunction

  task automatic tick();
    logic [15:0] v [2];
    bit          h [2];
    for (int i = 0; i < 2; i++) m_eval(i, v[i], h[i]);
    @(posedge clk);
    if (!rst_n) model_clear();
    else begin
      if (!stall_EX_DM) begin
        m_stg[2] = m_stg[1];
        m_stg[1] = stall_ID_EX ? BUB : m_ex;
        m_st     = v[0];
      end
      if (!stall_ID_EX) begin
        m_ex = flush_ID_EX ? BUB : {dst_addr_ID, dst_we_ID, dst_ld_ID};
        for (int i = 0; i < 2; i++) begin
          m_val[i]  = rf_rd_data[i*16 +: 16];
          m_src[i]  = rs_addr_ID[i*4 +: 4];
          m_wait[i] = rs_vld_ID[i] && m_src[i] != 4'h0 && !flush_ID_EX;
        end
      end else begin
        for (int i = 0; i < 2; i++)
          if (h[i]) begin m_val[i] = v[i]; m_wait[i] = 1'b0; end
      end
    end
  endtask

  task automatic idle();
    rst_n = 1'b1; stall_ID_EX = 1'b0; stall_EX_DM = 1'b0; flush_ID_EX = 1'b0;
    rs_addr_ID = 8'h0; rs_vld_ID = 2'b0; rf_rd_data = 32'h0;
    dst_addr_ID = 4'h0; dst_we_ID = 1'b0; dst_ld_ID = 1'b0; stg_data = 32'h0;
  endtask

  task automatic id_ins(input logic [3:0] a1, input logic [3:0] a0, input logic [1:0] vld,
                        input logic [3:0] dst, input logic we, input logic ld);
    rs_addr_ID = {a1, a0}; rs_vld_ID = vld; dst_addr_ID = dst; dst_we_ID = we; dst_ld_ID = ld;
  endtask

  task automatic drain();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); idle(); tick();
    end
  endtask

  task automatic test_reset();
    @(negedge clk); idle(); rst_n = 1'b0; tick();
    @(negedge clk); idle(); rst_n = 1'b0; tick();
    @(negedge clk); idle(); stg_data = 32'hFFFF_FFFF; id_ins(4'h3, 4'h3, 2'b11, 4'h0, 1'b0, 1'b0); #1;
    n_cmp++; if (opnd !== 32'h0) begin n_bad++; $display("FAIL reset_opnd got %h want %h", opnd, 32'h0); end
    n_cmp++; if (st_data_EX_DM !== 16'h0) begin n_bad++; $display("FAIL reset_st got %h want %h", st_data_EX_DM, 16'h0); end
    n_cmp++; if (byp_hit !== 2'b00 || load_use_haz !== 1'b0) begin n_bad++; $display("FAIL reset_hit got %b/%b want 00/0", byp_hit, load_use_haz); end
    $display("test_reset: opnd=%h st=%h byp=%b", opnd, st_data_EX_DM, byp_hit);
    tick();
    drain();
  endtask

  task automatic test_back_to_back();
    @(negedge clk); idle(); id_ins(4'h0, 4'h0, 2'b00, 4'h3, 1'b1, 1'b0); tick();
    @(negedge clk); idle(); id_ins(4'h3, 4'h3, 2'b11, 4'h9, 1'b0, 1'b0); rf_rd_data = 32'h7777_7777; tick();
    @(negedge clk); idle(); stg_data = {16'h0F0F, 16'h1234}; #1;
    n_cmp++; if (opnd !== 32'h1234_1234) begin n_bad++; $display("FAIL b2b_opnd got %h want %h", opnd, 32'h1234_1234); end
    n_cmp++; if (byp_hit !== 2'b11) begin n_bad++; $display("FAIL b2b_byp got %b want %b", byp_hit, 2'b11); end
    $display("test_back_to_back: opnd=%h byp=%b", opnd, byp_hit);
    tick();
    @(negedge clk); idle(); #1;
    n_cmp++; if (st_data_EX_DM !== 16'h1234) begin n_bad++; $display("FAIL b2b_st got %h want %h", st_data_EX_DM, 16'h1234); end
    tick();
    drain();
  endtask

  task automatic test_priority();
    @(negedge clk); idle(); id_ins(4'h0, 4'h0, 2'b00, 4'h5, 1'b1, 1'b0); tick();
    @(negedge clk); idle(); id_ins(4'h0, 4'h0, 2'b00, 4'h5, 1'b1, 1'b0); tick();
    @(negedge clk); idle(); id_ins(4'h0, 4'h5, 2'b01, 4'h0, 1'b0, 1'b0); tick();
    @(negedge clk); idle(); stg_data = {16'h5555, 16'hAAAA}; #1;
    n_cmp++; if (opnd[15:0] !== 16'hAAAA) begin n_bad++; $display("FAIL prio_t1 got %h want %h", opnd[15:0], 16'hAAAA); end
    n_cmp++; if (byp_hit !== 2'b01) begin n_bad++; $display("FAIL prio_t1_byp got %b want %b", byp_hit, 2'b01); end
    $display("test_priority T1: opnd0=%h byp=%b", opnd[15:0], byp_hit);
    tick();
    drain();
    @(negedge clk); idle(); id_ins(4'h0, 4'h0, 2'b00, 4'h5, 1'b1, 1'b0); tick();
    @(negedge clk); idle(); tick();
    @(negedge clk); idle(); id_ins(4'h0, 4'h5, 2'b01, 4'h0, 1'b0, 1'b0); tick();
    @(negedge clk); idle(); stg_data = {16'h5555, 16'hAAAA}; #1;
    n_cmp++; if (opnd[15:0] !== 16'h5555) begin n_bad++; $display("FAIL prio_t2 got %h want %h", opnd[15:0], 16'h5555); end
    $display("test_priority T2: opnd0=%h byp=%b", opnd[15:0], byp_hit);
    tick();
    drain();
  endtask

  task automatic test_stall_retention();
    logic [31:0] junk [3];
    junk[0] = {16'h0F0F, 16'hBEEF}; junk[1] = {16'h0BAD, 16'h0BAD}; junk[2] = {16'h1357, 16'h2468};
    @(negedge clk); idle(); id_ins(4'h0, 4'h0, 2'b00, 4'h2, 1'b1, 1'b0); tick();
    @(negedge clk); idle(); id_ins(4'h0, 4'h2, 2'b01, 4'h0, 1'b0, 1'b0); tick();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); idle(); stall_ID_EX = 1'b1; stg_data = junk[c];
      id_ins(4'h6, 4'h6, 2'b11, 4'h6, 1'b1, 1'b0); #1;
      n_cmp++; if (opnd[15:0] !== 16'hBEEF) begin n_bad++; $display("FAIL stall_opnd c%0d got %h want %h", c, opnd[15:0], 16'hBEEF); end
      n_cmp++; if (byp_hit[0] !== (c == 0)) begin n_bad++; $display("FAIL stall_byp c%0d got %b want %b", c, byp_hit[0], c == 0); end
      if (c > 0) begin
        n_cmp++; if (st_data_EX_DM !== 16'hBEEF) begin n_bad++; $display("FAIL stall_st c%0d got %h want %h", c, st_data_EX_DM, 16'hBEEF); end
      end
      $display("test_stall_retention c%0d: opnd0=%h byp=%b st=%h", c, opnd[15:0], byp_hit, st_data_EX_DM);
      tick();
    end
    drain();
  endtask

  task automatic test_load_use();
    @(negedge clk); idle(); id_ins(4'h0, 4'h0, 2'b00, 4'h4, 1'b1, 1'b1); tick();
    @(negedge clk); idle(); id_ins(4'h7, 4'h4, 2'b01, 4'h0, 1'b0, 1'b0); #1;
    n_cmp++; if (load_use_haz !== 1'b1) begin n_bad++; $display("FAIL lu_src0 got %b want 1", load_use_haz); end
    id_ins(4'h4, 4'h0, 2'b01, 4'h0, 1'b0, 1'b0); #1;
    n_cmp++; if (load_use_haz !== 1'b0) begin n_bad++; $display("FAIL lu_r0 got %b want 0", load_use_haz); end
    id_ins(4'h4, 4'h4, 2'b00, 4'h0, 1'b0, 1'b0); #1;
    n_cmp++; if (load_use_haz !== 1'b0) begin n_bad++; $display("FAIL lu_novld got %b want 0", load_use_haz); end
    id_ins(4'h4, 4'h1, 2'b10, 4'h0, 1'b0, 1'b0); #1;
    n_cmp++; if (load_use_haz !== 1'b1) begin n_bad++; $display("FAIL lu_src1 got %b want 1", load_use_haz); end
    $display("test_load_use: haz=%b", load_use_haz);
    flush_ID_EX = 1'b1; tick();
    @(negedge clk); idle(); id_ins(4'h0, 4'h0, 2'b00, 4'h0, 1'b1, 1'b1); tick();
    @(negedge clk); idle(); id_ins(4'h0, 4'h0, 2'b01, 4'h0, 1'b0, 1'b0); #1;
    n_cmp++; if (load_use_haz !== 1'b0) begin n_bad++; $display("FAIL lu_ld_r0 got %b want 0", load_use_haz); end
    flush_ID_EX = 1'b0; tick();
    drain();
  endtask

  task automatic test_r0();
    @(negedge clk); idle(); id_ins(4'h0, 4'h0, 2'b00, 4'h0, 1'b1, 1'b0); tick();
    @(negedge clk); idle(); id_ins(4'h0, 4'h0, 2'b01, 4'h0, 1'b0, 1'b0); tick();
    @(negedge clk); idle(); stg_data = 32'hFFFF_FFFF; #1;
    n_cmp++; if (opnd[15:0] !== 16'h0) begin n_bad++; $display("FAIL r0_opnd got %h want %h", opnd[15:0], 16'h0); end
    n_cmp++; if (byp_hit !== 2'b00) begin n_bad++; $display("FAIL r0_byp got %b want 00", byp_hit); end
    $display("test_r0: opnd0=%h byp=%b", opnd[15:0], byp_hit);
    tick();
    drain();
  endtask

  task automatic test_reset_mid();
    @(negedge clk); idle(); id_ins(4'h0, 4'h0, 2'b00, 4'h3, 1'b1, 1'b0); tick();
    @(negedge clk); idle(); id_ins(4'h3, 4'h3, 2'b11, 4'h4, 1'b1, 1'b1); rf_rd_data = 32'h1111_1111; tick();
    @(negedge clk); idle(); stall_ID_EX = 1'b1; stg_data = 32'h9999_9999; rst_n = 1'b0; tick();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); idle(); stall_ID_EX = 1'b1; stg_data = 32'h9999_9999;
      id_ins(4'h3, 4'h4, 2'b11, 4'h0, 1'b0, 1'b0); #1;
      n_cmp++; if (opnd !== 32'h0) begin n_bad++; $display("FAIL rstmid_opnd c%0d got %h want 0", c, opnd); end
      n_cmp++; if (byp_hit !== 2'b00 || load_use_haz !== 1'b0) begin n_bad++; $display("FAIL rstmid_hit c%0d got %b/%b want 00/0", c, byp_hit, load_use_haz); end
      n_cmp++; if (st_data_EX_DM !== 16'h0) begin n_bad++; $display("FAIL rstmid_st c%0d got %h want 0", c, st_data_EX_DM); end
      $display("test_reset_mid c%0d: opnd=%h byp=%b st=%h", c, opnd, byp_hit, st_data_EX_DM);
      tick();
    end
    @(negedge clk); idle(); id_ins(4'h3, 4'h3, 2'b11, 4'h0, 1'b0, 1'b0); rf_rd_data = 32'h4321_4321; tick();
    @(negedge clk); idle(); stg_data = 32'h9999_9999; #1;
    n_cmp++; if (opnd !== 32'h4321_4321 || byp_hit !== 2'b00) begin n_bad++; $display("FAIL rstmid_after got %h/%b want 43214321/00", opnd, byp_hit); end
    tick();
    drain();
  endtask

  task automatic test_random();
    logic [15:0] v0, v1;
    bit          h0, h1, hz;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      rst_n       = ($urandom_range(63) != 0);
      stall_EX_DM = ($urandom_range(5) == 0);
      stall_ID_EX = stall_EX_DM || ($urandom_range(4) == 0);
      rs_addr_ID  = {1'b0, 3'($urandom_range(7)), 1'b0, 3'($urandom_range(7))};
      rs_vld_ID   = 2'($urandom_range(3));
      rf_rd_data  = $urandom;
      stg_data    = $urandom;
      dst_addr_ID = 4'($urandom_range(7));
      dst_we_ID   = ($urandom_range(3) != 0);
      dst_ld_ID   = ($urandom_range(3) == 0);
      flush_ID_EX = (m_haz() && !stall_ID_EX) || ($urandom_range(9) == 0);
      #1;
      m_eval(0, v0, h0); m_eval(1, v1, h1); hz = m_haz();
      n_cmp++; if (opnd !== {v1, v0}) begin n_bad++; $display("FAIL rand_opnd c%0d got %h want %h", c, opnd, {v1, v0}); end
      n_cmp++; if (byp_hit !== {h1, h0}) begin n_bad++; $display("FAIL rand_byp c%0d got %b want %b", c, byp_hit, {h1, h0}); end
      n_cmp++; if (load_use_haz !== hz) begin n_bad++; $display("FAIL rand_haz c%0d got %b want %b", c, load_use_haz, hz); end
      n_cmp++; if (st_data_EX_DM !== m_st) begin n_bad++; $display("FAIL rand_st c%0d got %h want %h", c, st_data_EX_DM, m_st); end
      $display("rand %0d: rst_n=%b stl=%b%b fl=%b opnd=%h byp=%b haz=%b st=%h",
               c, rst_n, stall_EX_DM, stall_ID_EX, flush_ID_EX, opnd, byp_hit, load_use_haz, st_data_EX_DM);
      tick();
    end
  endtask

  initial begin
    model_clear();
    idle();
    test_reset();
    test_back_to_back();
    test_priority();
    test_stall_retention();
    test_load_use();
    test_r0();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
